// File: rtl/uart_boot_loader_pkg.sv
// Shared types and constants for the UART program loader.
package boot_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         DATA_BITS     = 8;
    localparam int         STOP_BITS     = 1;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } boot_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_boot_loader_if.sv
// Instruction RAM write port plus core reset/status, as driven by the loader.
interface uart_boot_loader_if;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_rst;
    logic        load_done;
    logic        load_err;

    modport master (output mem_we, mem_addr, mem_wdata, core_rst, load_done, load_err);
    modport slave  (input  mem_we, mem_addr, mem_wdata, core_rst, load_done, load_err);
endinterface

// File: rtl/uart_boot_loader_rx.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling, glitch-rejecting start check.
module uart_rx
    import boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic       o_byte_valid,
    output logic [7:0] o_byte_data,
    output logic       o_frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_t     r_state;
    logic          r_meta, r_sync, r_prev;
    logic [CW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_valid, r_err;

    // Receive state machine; r_prev gives a true falling-edge start detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RX_IDLE;
            r_meta  <= 1'b1;
            r_sync  <= 1'b1;
            r_prev  <= 1'b1;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_meta  <= i_rx;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    r_baud <= '0;
                    r_bit  <= 3'd0;
                    if (r_prev && !r_sync) r_state <= RX_START;
                end
                RX_START: begin
                    if (r_baud == HALF_CNT) begin
                        r_baud  <= '0;
                        r_state <= r_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_baud == FULL_CNT) begin
                        r_baud  <= '0;
                        r_shift <= {r_sync, r_shift[7:1]};
                        if (r_bit == 3'(DATA_BITS - 1)) begin
                            r_bit   <= 3'd0;
                            r_state <= RX_STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_baud == FULL_CNT) begin
                        r_baud <= '0;
                        if (!r_sync) begin
                            r_err   <= 1'b1;
                            r_state <= RX_IDLE;
                        end else if (r_bit == 3'(STOP_BITS - 1)) begin
                            r_valid <= 1'b1;
                            r_data  <= r_shift;
                            r_state <= RX_IDLE;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign o_byte_valid = r_valid;
    assign o_byte_data  = r_data;
    assign o_frame_err  = r_err;
endmodule

// File: rtl/uart_boot_loader.sv
// Framed UART program loader: writes words to instruction RAM, then releases the core.
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          MAX_WORDS    = 1024,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_rx,
    uart_boot_loader_if.master  o_bus
);
    logic        w_byte_valid;
    logic [7:0]  w_byte_data;
    logic        w_frame_err;
    logic [15:0] w_len_n;

    boot_state_t r_state;
    logic [15:0] r_len;
    logic [15:0] r_idx;
    logic [7:0]  r_sum;
    logic [1:0]  r_byte_k;
    logic [23:0] r_word;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_core_rst;
    logic        r_load_done;
    logic        r_load_err;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk          (clk),
        .rst          (rst),
        .i_rx         (i_rx),
        .o_byte_valid (w_byte_valid),
        .o_byte_data  (w_byte_data),
        .o_frame_err  (w_frame_err)
    );

    assign w_len_n = {w_byte_data, r_len[7:0]};

    // Frame parser, word assembler, checksum and address generator.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_SYNC;
            r_len       <= 16'd0;
            r_idx       <= 16'd0;
            r_sum       <= 8'h00;
            r_byte_k    <= 2'd0;
            r_word      <= 24'h0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= BASE_ADDR;
            r_mem_wdata <= 32'h0;
            r_core_rst  <= 1'b1;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_frame_err && r_state != ST_DONE) begin
                r_state    <= ST_ERR;
                r_load_err <= 1'b1;
                r_core_rst <= 1'b1;
            end else if (w_byte_valid) begin
                case (r_state)
                    ST_SYNC: begin
                        if (w_byte_data == SYNC_BYTE) r_state <= ST_LEN_LO;
                    end
                    ST_LEN_LO: begin
                        r_len[7:0] <= w_byte_data;
                        r_state    <= ST_LEN_HI;
                    end
                    ST_LEN_HI: begin
                        r_len[15:8] <= w_byte_data;
                        r_idx       <= 16'd0;
                        r_sum       <= 8'h00;
                        r_byte_k    <= 2'd0;
                        if (w_len_n > 16'(MAX_WORDS)) begin
                            r_state    <= ST_ERR;
                            r_load_err <= 1'b1;
                        end else if (w_len_n == 16'd0) begin
                            r_state <= ST_CSUM;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        r_sum    <= r_sum + w_byte_data;
                        r_byte_k <= r_byte_k + 2'd1;
                        case (r_byte_k)
                            2'd0: r_word[7:0]   <= w_byte_data;
                            2'd1: r_word[15:8]  <= w_byte_data;
                            2'd2: r_word[23:16] <= w_byte_data;
                            2'd3: begin
                                r_mem_we    <= 1'b1;
                                r_mem_wdata <= {w_byte_data, r_word};
                                r_mem_addr  <= BASE_ADDR + 32'({r_idx, 2'b00});
                                r_idx       <= r_idx + 16'd1;
                                if (r_idx + 16'd1 == r_len) r_state <= ST_CSUM;
                            end
                            default: r_byte_k <= 2'd0;
                        endcase
                    end
                    ST_CSUM: begin
                        if (w_byte_data == r_sum) begin
                            r_state     <= ST_DONE;
                            r_core_rst  <= 1'b0;
                            r_load_done <= 1'b1;
                        end else begin
                            r_state    <= ST_ERR;
                            r_load_err <= 1'b1;
                        end
                    end
                    ST_DONE: r_state <= ST_DONE;
                    ST_ERR: begin
                        if (w_byte_data == SYNC_BYTE) begin
                            r_load_err <= 1'b0;
                            r_idx      <= 16'd0;
                            r_sum      <= 8'h00;
                            r_byte_k   <= 2'd0;
                            r_state    <= ST_LEN_LO;
                        end
                    end
                    default: r_state <= ST_SYNC;
                endcase
            end
        end
    end

    assign o_bus.mem_we    = r_mem_we;
    assign o_bus.mem_addr  = r_mem_addr;
    assign o_bus.mem_wdata = r_mem_wdata;
    assign o_bus.core_rst  = r_core_rst;
    assign o_bus.load_done = r_load_done;
    assign o_bus.load_err  = r_load_err;
endmodule

// File: tb/tb_uart_boot_loader.sv
// Randomized and directed frame tests for uart_boot_loader against a frame-level model.
module tb_uart_boot_loader;
    localparam int          CPB  = 8;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    logic rx;
    uart_boot_loader_if bus ();

    uart_boot_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE), .MAX_WORDS(1024)) dut (
        .clk   (clk),
        .rst   (rst),
        .i_rx  (rx),
        .o_bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] cap_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] frame_w[$];

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) cap_q.push_back({bus.mem_addr, bus.mem_wdata});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = stop_bit;
        idle(CPB);
        rx = 1'b1;
        idle(int'($urandom_range(1, 6)));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);
        cap_q.delete();
        exp_q.delete();
    endtask

    // Frame-level model: writes are frame_w[i] at BASE+4i, csum is the byte sum.
    task automatic send_frame(input logic [7:0] csum_delta);
        logic [7:0]  sum;
        logic [15:0] n;
        sum = 8'h00;
        n   = 16'(frame_w.size());
        send_byte(8'hA5, 1'b1);
        send_byte(n[7:0], 1'b1);
        send_byte(n[15:8], 1'b1);
        for (int i = 0; i < frame_w.size(); i++) begin
            for (int j = 0; j < 4; j++) begin
                send_byte(frame_w[i][8*j +: 8], 1'b1);
                sum = sum + frame_w[i][8*j +: 8];
            end
            exp_q.push_back({BASE + 32'(4 * i), frame_w[i]});
        end
        send_byte(sum + csum_delta, 1'b1);
        idle(20);
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_nwr"}, 64'(cap_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk({tag, "_wr"}, (i < cap_q.size()) ? cap_q[i] : 64'hFFFF_FFFF_FFFF_FFFF, exp_q[i]);
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic check_status(input string tag, input logic done, input logic err);
        chk({tag, "_core_rst"}, 64'(bus.core_rst), 64'(!done));
        chk({tag, "_done"}, 64'(bus.load_done), 64'(done));
        chk({tag, "_err"}, 64'(bus.load_err), 64'(err));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_we"}, 64'(bus.mem_we), 64'd0);
        chk({tag, "_addr"}, 64'(bus.mem_addr), 64'(BASE));
        chk({tag, "_wdata"}, 64'(bus.mem_wdata), 64'd0);
        check_status(tag, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] nb;
        logic [7:0] delta;
        rx  = 1'b1;
        rst = 1'b1;
        idle(4);
        check_reset_vals("reset");
        rst = 1'b0;
        idle(4);

        // Two-word program with correct checksum.
        frame_w = '{32'h0010_0513, 32'h0020_0193};
        send_frame(8'h00);
        check_writes("img");
        check_status("img", 1'b1, 1'b0);
        send_frame(8'h00);
        exp_q.delete();
        check_writes("done_ign");
        check_status("done_ign", 1'b1, 1'b0);

        // Bad checksum then a clean resend.
        do_reset();
        send_frame(8'h01);
        check_writes("badcs");
        check_status("badcs", 1'b0, 1'b1);
        send_frame(8'h00);
        check_writes("resend");
        check_status("resend", 1'b1, 1'b0);

        // Noise before sync.
        do_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h5A, 1'b1);
        frame_w = '{32'hDEAD_BEEF};
        send_frame(8'h00);
        check_writes("noise");
        check_status("noise", 1'b1, 1'b0);

        // Length one above MAX_WORDS.
        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h04, 1'b1);
        idle(20);
        check_writes("toolong");
        check_status("toolong", 1'b0, 1'b1);

        // Zero-length frame.
        do_reset();
        frame_w.delete();
        send_frame(8'h00);
        check_writes("zero");
        check_status("zero", 1'b1, 1'b0);

        // Stop bit low on the 3rd data byte.
        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h10, 1'b0);
        send_byte(8'h00, 1'b1);
        idle(20);
        check_writes("ferr");
        check_status("ferr", 1'b0, 1'b1);

        // Short low glitch in the middle of a word must not add a byte.
        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hEF, 1'b1);
        rx = 1'b0;
        idle(2);
        rx = 1'b1;
        idle(20);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hDE, 1'b1);
        send_byte(8'h38, 1'b1);
        idle(20);
        exp_q.push_back({BASE, 32'hDEAD_BEEF});
        check_writes("glitch");
        check_status("glitch", 1'b1, 1'b0);

        // Reset during the second word of a two-word load.
        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h93, 1'b1);
        send_byte(8'h01, 1'b1);
        exp_q.push_back({BASE, 32'h0010_0513});
        check_writes("pre_rst");
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");
        send_byte(8'h20, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hDC, 1'b1);
        idle(20);
        check_writes("after_rst");
        check_status("after_rst", 1'b0, 1'b0);
        frame_w = '{32'h0010_0513, 32'h0020_0193};
        send_frame(8'h00);
        check_writes("fresh");
        check_status("fresh", 1'b1, 1'b0);

        // Randomized frames with optional noise and corrupted checksums.
        for (int it = 0; it < 6; it++) begin
            do_reset();
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                nb = 8'($urandom);
                if (nb == 8'hA5) nb = 8'h3C;
                send_byte(nb, 1'b1);
            end
            frame_w.delete();
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) frame_w.push_back($urandom);
            delta = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            send_frame(delta);
            check_writes("rand");
            check_status("rand", delta == 8'h00, delta != 8'h00);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
